// File: rtl/branch_redirect_unit.sv
// -----------------------------------------------------------------------------
// branch_redirect_unit
//
// Resolves conditional branches, JAL and JALR in the EX stage and drives the
// PC redirect port. A taken control transfer registers its target on `jump`,
// raises `JumpPC` for exactly one cycle and holds both pipeline flushes high
// for two cycles, which kills the two wrong-path instructions fetched behind
// it. While a redirect is in progress, EX inputs are ignored.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | sampling EX; a taken, valid, unstalled instruction redirects
//   REDIRECT | JumpPC strobe, both flushes, redirect counter advances
//   FLUSH    | both flushes only; EX holds a wrong-path instruction
//
// Ports
//   clk             clock
//   rst             asynchronous reset, active low
//   valid_ex        EX stage holds a valid instruction
//   stall           pipeline stall; EX is not sampled while high
//   is_branch       conditional branch
//   is_jal          JAL
//   is_jalr         JALR (highest priority of the three flags)
//   funct3          branch condition select
//   rs1_val         operand 1 (also the JALR base)
//   rs2_val         operand 2
//   pc_ex           PC of the EX instruction (word address)
//   imm             signed word offset, PCW bits
//   jump            registered redirect target; holds between redirects
//   JumpPC          one-cycle redirect strobe to the PC
//   flush_if_id     kill IF/ID
//   flush_id_ex     kill ID/EX
//   link_addr       pc_ex + 1, combinational
//   redirect_count  wrapping count of redirects issued
// -----------------------------------------------------------------------------
module branch_redirect_unit #(
  parameter int XLEN = 32,
  parameter int PCW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_ex,
  input  logic            stall,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [PCW-1:0]  pc_ex,
  input  logic [PCW-1:0]  imm,
  output logic [PCW-1:0]  jump,
  output logic            JumpPC,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [PCW-1:0]  link_addr,
  output logic [15:0]     redirect_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] jump_q, jump_d;
  logic [15:0]    count_q, count_d;

  logic           eq, lt_s, lt_u;
  logic           cond_met;
  logic           taken;
  logic           accept;
  logic [PCW-1:0] target;

  // ---------------------------------------------------------------------------
  // Branch condition evaluation
  // ---------------------------------------------------------------------------
  assign eq   = (rs1_val == rs2_val);
  assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign lt_u = (rs1_val < rs2_val);

  always_comb begin
    cond_met = 1'b0;
    case (funct3)
      3'b000:  cond_met = eq;
      3'b001:  cond_met = ~eq;
      3'b100:  cond_met = lt_s;
      3'b101:  cond_met = ~lt_s;
      3'b110:  cond_met = lt_u;
      3'b111:  cond_met = ~lt_u;
      default: cond_met = 1'b0;   // 010 / 011 are not branch encodings
    endcase
  end

  assign taken = is_jalr | is_jal | (is_branch & cond_met);

  // imm is already PCW wide, so sign extension within PCW is the identity and
  // the PCW-bit sum wraps mod 2^PCW on its own. JALR wins over the other flags.
  always_comb begin
    target = pc_ex + imm;
    if (is_jalr) begin
      target = rs1_val[PCW-1:0] + imm;
    end
  end

  assign accept    = (state_q == IDLE) & valid_ex & ~stall;
  assign link_addr = pc_ex + PCW'(1);

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  // Strobe and flushes decode straight from the state register so that an
  // asynchronous reset drops them immediately, even mid-redirect.
  always_comb begin
    state_d     = state_q;
    jump_d      = jump_q;
    count_d     = count_q;
    JumpPC      = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && taken) begin
          jump_d  = target;
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        JumpPC      = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        count_d     = count_q + 16'd1;
        state_d     = FLUSH;
      end
      FLUSH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      jump_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      jump_q  <= jump_d;
      count_q <= count_d;
    end
  end

  assign jump           = jump_q;
  assign redirect_count = count_q;

endmodule
